// File: rtl/raster_pkg.sv
// raster_pkg: shared coordinate widths, edge-value width and vertex types for the raster core
package raster_pkg;
  localparam int COL_W = 10;
  localparam int ROW_W = 9;
  localparam int EDGE_W = COL_W + ROW_W + 3;
  typedef logic [COL_W-1:0] col_t;
  typedef logic [ROW_W-1:0] row_t;
  typedef logic signed [EDGE_W-1:0] edge_t;
  typedef struct packed {
    col_t x0;
    col_t x1;
    col_t x2;
    row_t y0;
    row_t y1;
    row_t y2;
  } vtx3_t;
endpackage

// File: rtl/raster_core_pipe_edge_fn.sv
// raster_edge_fn: two-stage edge function (b-a) x (p-a); differences then cross products, E is their difference
module raster_edge_fn
  import raster_pkg::*;
#(
  parameter int X_W = COL_W,
  parameter int Y_W = ROW_W,
  localparam int EW = X_W + Y_W + 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [X_W-1:0]       ax,
  input  logic [Y_W-1:0]       ay,
  input  logic [X_W-1:0]       bx,
  input  logic [Y_W-1:0]       by,
  input  logic [X_W-1:0]       px,
  input  logic [Y_W-1:0]       py,
  output logic signed [EW-1:0] e
);
  logic signed [X_W:0] dx_ab, dx_pa;
  logic signed [Y_W:0] dy_ab, dy_pa;
  logic signed [EW-1:0] p0, p1;
  // S1 registers signed differences, S2 registers the two cross products
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dx_ab <= '0;
      dx_pa <= '0;
      dy_ab <= '0;
      dy_pa <= '0;
      p0 <= '0;
      p1 <= '0;
    end else begin
      dx_ab <= $signed({1'b0, bx}) - $signed({1'b0, ax});
      dx_pa <= $signed({1'b0, px}) - $signed({1'b0, ax});
      dy_ab <= $signed({1'b0, by}) - $signed({1'b0, ay});
      dy_pa <= $signed({1'b0, py}) - $signed({1'b0, ay});
      p0 <= EW'(dx_ab) * EW'(dy_pa);
      p1 <= EW'(dy_ab) * EW'(dx_pa);
    end
  assign e = p0 - p1;
endmodule

// File: rtl/raster_core_pipe.sv
// raster_core_pipe: NUM_TRI-slot pipelined triangle hit test, latency 3; RASTER_BOTH_WINDING_EN also accepts the all-E<=0 winding
module raster_core_pipe
  import raster_pkg::*;
#(
  parameter int NUM_TRI = 4,
  parameter int X_W = COL_W,
  parameter int Y_W = ROW_W,
  localparam int IDX_W = (NUM_TRI > 1) ? $clog2(NUM_TRI) : 1,
  localparam int EW = X_W + Y_W + 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tri_wr_en,
  input  logic [IDX_W-1:0] tri_wr_idx,
  input  logic [X_W-1:0]   tri_v0_x,
  input  logic [X_W-1:0]   tri_v1_x,
  input  logic [X_W-1:0]   tri_v2_x,
  input  logic [Y_W-1:0]   tri_v0_y,
  input  logic [Y_W-1:0]   tri_v1_y,
  input  logic [Y_W-1:0]   tri_v2_y,
  input  logic             tri_clear,
  input  logic             pix_valid,
  input  logic [X_W-1:0]   pixel_col,
  input  logic [Y_W-1:0]   pixel_row,
  output logic             out_valid,
  output logic             out_hit,
  output logic [IDX_W-1:0] out_tri_idx,
  output logic [X_W-1:0]   out_col,
  output logic [Y_W-1:0]   out_row
);
  logic [X_W-1:0] sx [NUM_TRI][3];
  logic [Y_W-1:0] sy [NUM_TRI][3];
  logic [NUM_TRI-1:0] sv, sv1, sv2, hits;
  logic signed [EW-1:0] ev [NUM_TRI][3];
  logic v1, v2;
  logic [X_W-1:0] c1, c2;
  logic [Y_W-1:0] r1, r2;
  logic [IDX_W-1:0] idx;
  // slot bank; a clear lands before a same-cycle write so the written slot stays valid
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sv <= '0;
      for (int t = 0; t < NUM_TRI; t++)
        for (int k = 0; k < 3; k++) begin
          sx[t][k] <= '0;
          sy[t][k] <= '0;
        end
    end else begin
      if (tri_clear) sv <= '0;
      for (int t = 0; t < NUM_TRI; t++)
        if (tri_wr_en && tri_wr_idx == IDX_W'(t)) begin
          sx[t][0] <= tri_v0_x;
          sx[t][1] <= tri_v1_x;
          sx[t][2] <= tri_v2_x;
          sy[t][0] <= tri_v0_y;
          sy[t][1] <= tri_v1_y;
          sy[t][2] <= tri_v2_y;
          sv[t] <= 1'b1;
        end
    end
  for (genvar t = 0; t < NUM_TRI; t++) begin : g_tri
    for (genvar k = 0; k < 3; k++) begin : g_edge
      raster_edge_fn #(.X_W(X_W), .Y_W(Y_W)) u_edge (
        .clk(clk),
        .rst(rst),
        .ax(sx[t][k]),
        .ay(sy[t][k]),
        .bx(sx[t][(k+1)%3]),
        .by(sy[t][(k+1)%3]),
        .px(pixel_col),
        .py(pixel_row),
        .e(ev[t][k])
      );
    end
  end
  // S3 sign test per triangle masked by the slot valid seen at S1, lowest index wins
  always_comb begin
    hits = '0;
    idx = '0;
    for (int t = 0; t < NUM_TRI; t++) begin
      hits[t] = !(ev[t][0][EW-1] || ev[t][1][EW-1] || ev[t][2][EW-1]);
`ifdef RASTER_BOTH_WINDING_EN
      hits[t] = hits[t] || ((ev[t][0][EW-1] || ev[t][0] == '0) &&
                            (ev[t][1][EW-1] || ev[t][1] == '0) &&
                            (ev[t][2][EW-1] || ev[t][2] == '0));
`endif
      hits[t] = hits[t] && sv2[t];
    end
    for (int t = NUM_TRI - 1; t >= 0; t--)
      if (hits[t]) idx = IDX_W'(t);
  end
  // pixel and slot-valid delay line beside the edge evaluators, then the result register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      c1 <= '0;
      c2 <= '0;
      r1 <= '0;
      r2 <= '0;
      sv1 <= '0;
      sv2 <= '0;
      out_valid <= 1'b0;
      out_hit <= 1'b0;
      out_tri_idx <= '0;
      out_col <= '0;
      out_row <= '0;
    end else begin
      v1 <= pix_valid;
      v2 <= v1;
      c1 <= pixel_col;
      c2 <= c1;
      r1 <= pixel_row;
      r2 <= r1;
      sv1 <= sv;
      sv2 <= sv1;
      out_valid <= v2;
      out_hit <= v2 && |hits;
      out_tri_idx <= (v2 && |hits) ? idx : '0;
      out_col <= c2;
      out_row <= r2;
    end
endmodule

// File: doc/raster_core_pipe.md
Name: raster_core_pipe

Overview:
- Parametrised, pipelined successor to the combinational single-triangle raster core.
- Holds up to NUM_TRI triangles in an internal register bank, loaded one at a time through a write port.
- Evaluates three edge functions per triangle on a streamed pixel coordinate. Reports hit/miss and the winning triangle index with fixed latency.
- Sits between the VGA timing generator (pixel stream source) and the colour/output mux.

Parameters:
- NUM_TRI, 4, number of triangle slots; must be ≥1. IDX_W = max(1, clog2(NUM_TRI)) is a derived localparam.
- X_W, 10, column coordinate width (unsigned).
- Y_W, 9, row coordinate width (unsigned).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tri_wr_en  in  1  load triangle slot this cycle
- tri_wr_idx  in  IDX_W  slot to load; values ≥NUM_TRI are ignored
- tri_v0_x, tri_v1_x, tri_v2_x  in  X_W each  vertex columns
- tri_v0_y, tri_v1_y, tri_v2_y  in  Y_W each  vertex rows
- tri_clear  in  1  invalidate all slots
- pix_valid  in  1  pixel coordinate present
- pixel_col  in  X_W  pixel column
- pixel_row  in  Y_W  pixel row
- out_valid  out  1  result present
- out_hit  out  1  pixel inside at least one valid triangle
- out_tri_idx  out  IDX_W  lowest-index hit triangle; 0 when no hit
- out_col  out  X_W  pixel column delayed to align with the result
- out_row  out  Y_W  pixel row delayed to align with the result

Behaviour:
- Reset (async assert, sync-safe deassert): all slot valid bits 0, vertex registers 0, pipeline valids 0. All outputs 0.
- Slot write: on a clk edge with tri_wr_en, store the six vertex values into slot tri_wr_idx and set its valid bit. The slot is visible to pixels accepted on the following edge onward. Pixels already in flight use the old values.
- tri_clear clears every valid bit on the next edge. If tri_clear and tri_wr_en occur in the same cycle, the clear applies first, so the written slot ends valid.
- Edge function for edge a→b at point p: E = (bx−ax)*(py−ay) − (by−ay)*(px−ax).
  - Differences are signed, X_W+1 and Y_W+1 bits.
  - Products and E are signed, EW = X_W+Y_W+3 bits; no overflow is possible.
- Edges evaluated: v0→v1, v1→v2, v2→v0. Inside when all three E ≥ 0. Boundaries are inclusive; no top-left rule.
- Degenerate (zero-area) triangles report hit only for points where all E = 0, which follows from the arithmetic.
- Pipeline, fixed latency 3 cycles, no stalls, one pixel accepted per cycle:
  - S1: register pixel, compute differences.
  - S2: register products.
  - S3: subtract, sign test, AND with slot valid, priority-encode (lowest index wins).
- out_valid equals pix_valid delayed 3 cycles. out_col/out_row equal the inputs delayed 3 cycles.
- When out_valid=0, out_hit and out_tri_idx are 0; out_col/out_row are don't-care.
- rst asserted mid-stream flushes the pipeline immediately; no partial results emerge after deassert.

Optional Feature:
- Macro: RASTER_BOTH_WINDING_EN.
- Defined: a pixel is also inside when all three E ≤ 0, so both windings rasterise.
- Undefined: only the all-E ≥ 0 winding hits; the opposite winding is back-face culled.

Decomposition:
- Package raster_pkg holds the coordinate width constants, EW, typedefs for x/y coordinate and signed edge value, and a vertex-triple struct.
- Sub-module raster_edge_fn: one two-stage edge evaluator covering S1 and S2, instantiated 3×NUM_TRI times. The top level holds the slot bank, S3 compare/priority logic and delay lines.

Test Plan:
- Reset: hold rst with pix_valid=1 → all outputs 0; after release, first out_valid appears exactly 3 cycles after the first pix_valid.
- Slot 0 = (0,0),(100,0),(0,100):
  - pixel (10,10) → out_hit=1, out_tri_idx=0, out_col=10, out_row=10 at +3.
  - pixel (90,90) → out_hit=0.
  - pixel (50,50), on the hypotenuse, → hit.
- Overlap/priority: slot 2 = (0,0),(200,0),(0,200) and slot 1 = (0,0),(100,0),(0,100). Pixel (10,10) → idx 1; pixel (150,20) → idx 2.
- Winding: slot 0 = (0,0),(0,100),(100,0), pixel (10,10) → miss without RASTER_BOTH_WINDING_EN, hit with idx 0 when it is defined.
- Back-to-back stream of 8 pixels while rewriting slot 0 mid-stream:
  - pixels issued before the write use the old triangle; pixels after use the new one.
  - out_valid stays continuous.
- tri_clear plus a same-cycle write to slot 3 → only slot 3 is valid; previously hitting pixels in slots 0–2 now miss.
- Extra case when NUM_TRI<4: write with tri_wr_idx ≥ NUM_TRI → no state change.
